// File: rtl/sram_ctrl.sv
// Single-beat request to asynchronous SRAM cycle sequencer for the HM65256B (32K x 8).
// Each access is a CE-framed cycle whose phases are timed by one shared down-counter.
module sram_ctrl #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  wire  [DATA_W-1:0] sram_data_io,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_ACCESS  = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // The counter holds "cycles remaining minus one", so a phase ends when it reads zero.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              drive_q, drive_d;
    logic              accept;
    logic              sample_rd;

    assign accept    = req_valid_i && (state_q == ST_IDLE);
    assign sample_rd = (state_q == ST_ACCESS) && !we_q && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = we_q ? ST_HOLD : ST_RECOVER;
                    cnt_d   = we_q ? HOLD_LD : '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pins are decoded from the next state and registered, so they change cleanly with the state.
    always_comb begin
        ready_d     = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RECOVER);
        ce_n_d      = !((state_d == ST_ACCESS) || (state_d == ST_HOLD));
        oe_n_d      = !((state_d == ST_ACCESS) && !we_q);
        we_n_d      = !((state_d == ST_ACCESS) && we_q);
        drive_d     = ((state_d == ST_ACCESS) || (state_d == ST_HOLD)) && we_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            drive_q     <= drive_d;
            if (accept) begin
                we_q    <= req_we_i;
                wdata_q <= req_wdata_i;
                addr_q  <= req_addr_i;
            end
            if (sample_rd) begin
                rdata_q <= sram_data_io;
            end
        end
    end

    assign req_ready_o  = ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rdata_q;
    assign sram_addr_o  = addr_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_data_io = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

- Synchronous controller that turns single-beat read/write requests into correctly sequenced asynchronous SRAM cycles for the 32K x 8 HM65256B part on the DE0 board.
- Sits directly upstream of the SRAM and drives its address, data, CE, OE and WE pins.
- The SRAM latches the address on CE falling and writes on WE rising with CE low, so every access is a full CE-framed cycle generated from counted wait states.
- One request is outstanding at a time; there is no queueing.

## Interface
Parameters:
- ADDR_W, 15, address width (32K locations)
- DATA_W, 8, data width
- SETUP_CYC, 1, cycles the address is stable with CE high before CE falls (minimum 1)
- PULSE_CYC, 4, cycles CE is low with the OE or WE strobe active; default gives 80 ns at 50 MHz, which covers the 70 ns access time (minimum 1)
- HOLD_CYC, 1, write cycles with WE high, CE low and data still driven (minimum 1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, 50 MHz on DE0
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle; the request is accepted on a clk edge where valid and ready are both 1
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  single-cycle completion pulse, for reads and writes
- rsp_rdata  out  DATA_W  read data; holds its value until the next read completes
- sram_addr  out  ADDR_W  SRAM address pins
- sram_data  inout  DATA_W  SRAM data pins
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM active-low strobes

## Operation
- States: IDLE, SETUP, ACCESS, HOLD, RECOVER.
- All pin outputs are registered and are decoded from the registered state, so the strobes are glitch-free.
- req_ready = 1 only in IDLE.
- On accept, req_we, req_addr and req_wdata are captured. Request inputs are ignored at all other times.
- IDLE -> SETUP on accept. sram_addr is loaded with the captured address; CE_n=1, OE_n=1, WE_n=1.
- SETUP, after SETUP_CYC cycles -> ACCESS. CE_n=0.
  - Read: OE_n=0 and the data bus is not driven.
  - Write: WE_n=0 and the data bus drives the captured data.
- ACCESS, after PULSE_CYC cycles:
  - Read -> RECOVER. sram_data is sampled into rsp_rdata on this transition edge.
  - Write -> HOLD.
- HOLD, after HOLD_CYC cycles -> RECOVER. WE_n=1 (this rising edge commits the write), CE_n=0, data still driven.
- RECOVER, 1 cycle -> IDLE. CE_n=1, OE_n=1, WE_n=1, bus released, rsp_valid=1.
- sram_addr is held from SETUP through RECOVER. It changes only on the next accept.
- Bus contention rule: the data bus is driven only in write ACCESS and HOLD. OE_n=0 only in read ACCESS. Both are never true in the same cycle.
- A single down-counter, sized for max(SETUP_CYC, PULSE_CYC, HOLD_CYC), times every state. It is reloaded on every state entry.

## Timing
- Cycle 0 is the accept edge. With S=SETUP_CYC, P=PULSE_CYC, H=HOLD_CYC:
  - SETUP covers cycles 1..S.
  - ACCESS covers cycles S+1..S+P.
  - Read: RECOVER/rsp_valid at cycle S+P+1; rsp_rdata is valid in the same cycle.
  - Write: HOLD covers cycles S+P+1..S+P+H; RECOVER/rsp_valid at cycle S+P+H+1.
  - req_ready rises the cycle after RECOVER.
- With defaults:
  - Read: rsp_valid at cycle 6; one read per 7 cycles.
  - Write: rsp_valid at cycle 7; one write per 8 cycles.
- CE_n is high for at least 1 cycle (RECOVER) between accesses, so every access gives the SRAM a fresh CE falling edge with a stable address.
- Reset values (asynchronous, immediate):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0.
  - sram_addr = 0, CE_n = OE_n = WE_n = 1, data bus = Z.
- Reset during a write ACCESS or HOLD: the strobes rise immediately. Contents of that one address are undefined; no other location may change.
- Reset during a read: no rsp_valid pulse is produced.
- req_valid held high through a busy period: that request is accepted on the first IDLE edge.

## Test plan
- Write addr 0x1234, data 0xA5; then read 0x1234. Required: read rsp_valid at cycle 6, rsp_rdata = 0xA5; write rsp_valid at cycle 7. Check the strobe sequence matches Timing exactly.
- Back-to-back writes to 0x0000 = 0x11 and 0x7FFF = 0xEE with req_valid held high, then read both. Required: 0x11 and 0xEE returned; req_ready low for exactly 7 cycles per write; CE_n high between accesses.
- Every cycle, assert: the data bus is never driven while OE_n = 0, and sram_addr is stable whenever CE_n = 0.
- Assert rst_n in cycle 3 of a write of 0x3C to 0x0100. Required: all strobes 1 and bus Z immediately; no rsp_valid. A later read of 0x0101 (preloaded with 0x77) returns 0x77.
- With SETUP_CYC=2, PULSE_CYC=1, HOLD_CYC=3: write then read 0x2AAA = 0x5F. Required: write rsp_valid at cycle 7, read rsp_valid at cycle 4, data 0x5F.
- Toggle req_addr and req_wdata while the controller is busy. Required: the in-flight access is unaffected.
